// File: rtl/branch_target_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_target_predictor_if
//   Bundles the fetch-side lookup, the decode-side training strobe and the
//   statistic outputs of branch_target_predictor.
//
//   Handshake: there is no back-pressure. The lookup is a pure combinational
//   query on if_pc. A training update is accepted in every cycle where
//   upd_valid && upd_is_branch is high at a rising clock edge with reset low.
//   There is no ready signal and no acknowledge.
//
//   Modports
//     master : the pipeline side. It drives if_pc and upd_*, and reads
//              pred_* and stat_*.
//     slave  : the predictor side, with the opposite directions.
// ----------------------------------------------------------------------------
interface branch_target_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid;
  logic              upd_is_branch;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_mispred;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output if_pc, upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
           upd_mispred,
    input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispred
  );

  modport slave (
    input  if_pc, upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
           upd_mispred,
    output pred_hit, pred_taken, pred_target, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_target_predictor.sv
// ----------------------------------------------------------------------------
// branch_target_predictor
//   Dynamic branch predictor built from a direct-mapped BTB and saturating
//   counters. The IF stage gets a zero-latency lookup on if_pc. The ID stage
//   trains the tables with resolved beq/jal outcomes. The block also keeps
//   saturating counts of trained branches and of mispredicts.
//
//   Ports
//     clk   : rising-edge clock
//     reset : synchronous, active-high. It clears every table entry and both
//             statistic counters, drops any update in the same cycle, and
//             forces the lookup outputs to 0.
//     bus   : branch_target_predictor_if.slave. It carries the lookup
//             (if_pc -> pred_*), the update (upd_*) and the statistics
//             (stat_*).
//
//   Optional feature macro: BTP_GSHARE_EN.
//     When it is defined, the counters are indexed by the pc index XOR an
//     IDX_W-bit global history register. Tags and targets stay pc-indexed.
//
//   Address split
//     index = pc[IDX_W+1:2]
//     tag   = pc[IDX_W+TAG_W+1:IDX_W+2]
// ----------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  branch_target_predictor_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_mispred_q;

  logic [IDX_W-1:0]  lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, up_hit, up_en;

  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign lk_tag = bus.if_pc[TAG_HI:TAG_LO];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[TAG_HI:TAG_LO];

`ifdef BTP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  // Keep the low IDX_W bits of {ghr, outcome}. This also works when IDX_W == 1.
  logic [IDX_W:0]   ghr_cat;
  assign ghr_cat = {ghr_q, bus.upd_taken};
  // Lookup and training both use the history as it stands before this update.
  assign lk_cidx = lk_idx ^ ghr_q;
  assign up_cidx = up_idx ^ ghr_q;
`else
  assign lk_cidx = lk_idx;
  assign up_cidx = up_idx;
`endif

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en  = bus.upd_valid && bus.upd_is_branch;

  // The lookup reads registered state only. An update to the same entry in
  // this cycle shows up in the lookup from the next cycle.
  always_comb begin
    bus.pred_hit    = 1'b0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    if (!reset && lk_hit) begin
      bus.pred_hit    = 1'b1;
      bus.pred_taken  = ctr_q[lk_cidx][CTR_W-1];
      bus.pred_target = target_q[lk_idx];
    end
  end

  assign bus.stat_branches = stat_branches_q;
  assign bus.stat_mispred  = stat_mispred_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
`ifdef BTP_GSHARE_EN
      ghr_q <= '0;
`endif
    end else if (up_en) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          if (ctr_q[up_cidx] != CTR_MAX) ctr_q[up_cidx] <= ctr_q[up_cidx] + CTR_W'(1);
          target_q[up_idx] <= bus.upd_target;
        end else if (ctr_q[up_cidx] != '0) begin
          ctr_q[up_cidx] <= ctr_q[up_cidx] - CTR_W'(1);
        end
      end else if (bus.upd_taken) begin
        // A taken branch that misses takes over the slot and starts weakly taken.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        ctr_q[up_cidx]   <= CTR_WEAK;
      end
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + STAT_W'(1);
      if (bus.upd_mispred && (stat_mispred_q != '1))
        stat_mispred_q <= stat_mispred_q + STAT_W'(1);
`ifdef BTP_GSHARE_EN
      ghr_q <= ghr_cat[IDX_W-1:0];
`endif
    end
  end

  // The byte-offset bits and the bits above the tag do not take part in
  // indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:TAG_HI+1],
                            bus.upd_pc[1:0], bus.upd_pc[XLEN-1:TAG_HI+1]};
endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
  localparam int XLEN   = 32;
  localparam int STAT_W = 32;
  localparam int W      = 2 + XLEN + 2 * STAT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.XLEN(XLEN), .STAT_W(STAT_W)) bus ();

  branch_target_predictor #(
    .XLEN(XLEN), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Statistics model: updates are credited after the edge that captures them.
  logic [STAT_W-1:0] m_branches = '0;
  logic [STAT_W-1:0] m_mispred  = '0;
  logic pend_b = 1'b0, pend_m = 1'b0, pend_rst = 1'b0;

  // ---------------- driver tasks ----------------
  // One cycle: at the falling edge, retire the previous cycle's effect into
  // the model, then drive the new inputs.
  task automatic step(input logic rst, input logic [31:0] lk_pc,
                      input logic uv, input logic ub, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic um);
    @(negedge clk);
    if (pend_rst) begin
      m_branches = '0;
      m_mispred  = '0;
    end else begin
      if (pend_b && m_branches != '1) m_branches = m_branches + 1;
      if (pend_m && m_mispred  != '1) m_mispred  = m_mispred + 1;
    end
    pend_rst = rst;
    pend_b   = !rst && uv && ub;
    pend_m   = !rst && uv && ub && um;
    reset             = rst;
    bus.if_pc         = lk_pc;
    bus.upd_valid     = uv;
    bus.upd_is_branch = ub;
    bus.upd_pc        = upc;
    bus.upd_taken     = ut;
    bus.upd_target    = utgt;
    bus.upd_mispred   = um;
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b0, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lk_pc, input logic [31:0] pc,
                     input logic taken, input logic [31:0] tgt, input logic mis);
    step(1'b0, lk_pc, 1'b1, 1'b1, pc, taken, tgt, mis);
  endtask

  // Push the expected lookup result for the current cycle, then pop it and
  // compare once the combinational outputs have settled.
  task automatic expect_out(input string tag, input logic hit, input logic taken,
                            input logic [31:0] tgt);
    logic [W-1:0] e;
    exp_q.push_back({hit, taken, tgt, m_branches, m_mispred});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    assert (bus.pred_hit === e[W-1])
      else begin n_fail++; $error("FAIL %s pred_hit observed=%0b expected=%0b", tag, bus.pred_hit, e[W-1]); end
    n_checks++;
    assert (bus.pred_taken === e[W-2])
      else begin n_fail++; $error("FAIL %s pred_taken observed=%0b expected=%0b", tag, bus.pred_taken, e[W-2]); end
    n_checks++;
    assert (bus.pred_target === e[W-3 -: XLEN])
      else begin n_fail++; $error("FAIL %s pred_target observed=%h expected=%h", tag, bus.pred_target, e[W-3 -: XLEN]); end
    n_checks++;
    assert (bus.stat_branches === e[2*STAT_W-1 -: STAT_W])
      else begin n_fail++; $error("FAIL %s stat_branches observed=%0d expected=%0d", tag, bus.stat_branches, e[2*STAT_W-1 -: STAT_W]); end
    n_checks++;
    assert (bus.stat_mispred === e[STAT_W-1:0])
      else begin n_fail++; $error("FAIL %s stat_mispred observed=%0d expected=%0d", tag, bus.stat_mispred, e[STAT_W-1:0]); end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.if_pc = '0; bus.upd_valid = 1'b0; bus.upd_is_branch = 1'b0;
    bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispred = 1'b0;

    // Reset, then the empty table.
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_out("in_reset", 1'b0, 1'b0, 32'h0);
    look(32'h40);                       expect_out("reset_empty", 1'b0, 1'b0, 32'h0);

    // Allocation. The same cycle still sees the old state.
    upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0); expect_out("alloc_same", 1'b0, 1'b0, 32'h0);
    look(32'h40);                       expect_out("alloc_next", 1'b1, 1'b1, 32'h100);

    // Counter walk 2 -> 1 -> 0 -> 0, then 1,2,3,3. Each check shows the state before the update.
    upd(32'h40, 32'h40, 1'b0, 32'hdead, 1'b0); expect_out("nt1", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'hdead, 1'b0); expect_out("nt2", 1'b1, 1'b0, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'hdead, 1'b0); expect_out("nt3", 1'b1, 1'b0, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0); expect_out("t1_ctr0", 1'b1, 1'b0, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0); expect_out("t2_ctr1", 1'b1, 1'b0, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0); expect_out("t3_ctr2", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h108, 1'b0); expect_out("t4_ctr3", 1'b1, 1'b1, 32'h100);
    // If the counter saturated at 3, one not-taken update leaves 2, which is still taken.
    upd(32'h40, 32'h40, 1'b0, 32'hbeef, 1'b0); expect_out("sat_ctr3", 1'b1, 1'b1, 32'h108);
    look(32'h40);                       expect_out("sat_ctr2", 1'b1, 1'b1, 32'h108);

    // Alias at index 0: 0x440 replaces 0x40.
    look(32'h440);                      expect_out("alias_miss", 1'b0, 1'b0, 32'h0);
    upd(32'h440, 32'h440, 1'b1, 32'h200, 1'b0); expect_out("alias_upd", 1'b0, 1'b0, 32'h0);
    look(32'h440);                      expect_out("alias_hit", 1'b1, 1'b1, 32'h200);
    look(32'h40);                       expect_out("alias_evict", 1'b0, 1'b0, 32'h0);

    // Updates that must not change the tables: is_branch=0, valid=0, and a not-taken miss.
    step(1'b0, 32'hc0, 1'b1, 1'b0, 32'hc0, 1'b1, 32'h500, 1'b1); expect_out("nobr_same", 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'hc0, 1'b0, 1'b1, 32'hc0, 1'b1, 32'h500, 1'b1); expect_out("noval_same", 1'b0, 1'b0, 32'h0);
    upd(32'hc0, 32'hc0, 1'b0, 32'h500, 1'b0); expect_out("nt_miss_same", 1'b0, 1'b0, 32'h0);
    look(32'hc0);                       expect_out("nt_miss_after", 1'b0, 1'b0, 32'h0);
    look(32'h440);                      expect_out("entry_kept", 1'b1, 1'b1, 32'h200);

    // Same-cycle update and lookup on 0x80.
    upd(32'h80, 32'h80, 1'b1, 32'h300, 1'b0); expect_out("bypass_none", 1'b0, 1'b0, 32'h0);
    look(32'h80);                       expect_out("bypass_next", 1'b1, 1'b1, 32'h300);

    // Populate two more entries, both flagged as mispredicts.
    upd(32'h104, 32'h104, 1'b1, 32'h600, 1'b1); expect_out("pop1_same", 1'b0, 1'b0, 32'h0);
    upd(32'h208, 32'h208, 1'b1, 32'h700, 1'b1); expect_out("pop2_same", 1'b0, 1'b0, 32'h0);
    look(32'h104);                      expect_out("pop1_hit", 1'b1, 1'b1, 32'h600);
    look(32'h208);                      expect_out("pop2_hit", 1'b1, 1'b1, 32'h700);

    // Reset with an update in the same cycle. The update is dropped and everything clears.
    step(1'b1, 32'h80, 1'b1, 1'b1, 32'h30c, 1'b1, 32'h800, 1'b1); expect_out("rst_forced", 1'b0, 1'b0, 32'h0);
    look(32'h80);                       expect_out("rst_clr_80", 1'b0, 1'b0, 32'h0);
    look(32'h104);                      expect_out("rst_clr_104", 1'b0, 1'b0, 32'h0);
    look(32'h30c);                      expect_out("rst_drop", 1'b0, 1'b0, 32'h0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
